// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle MIPS-subset control FSM: sequences IF/ID/EXE/MEM/WB and decodes every datapath
// strobe from the registered state, the latched opcode and the ALU zero flag.
module multi_cycle_control_unit #(
  parameter logic [5:0]  HALT_OP = 6'b111111,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [5:0]       opCode,
  input  logic             zero,
  output logic             PCWre,
  output logic [1:0]       PCSrc,
  output logic             IRWre,
  output logic             InsMemRW,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic             ExtSel,
  output logic [1:0]       RegDst,
  output logic             WrRegDSrc,
  output logic             RegWre,
  output logic             DBDataSrc,
  output logic             mRD,
  output logic             mWR,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count,
  output logic             halted
);

  localparam logic [5:0] OpAdd   = 6'b000000;
  localparam logic [5:0] OpSub   = 6'b000001;
  localparam logic [5:0] OpAddiu = 6'b000010;
  localparam logic [5:0] OpAnd   = 6'b010000;
  localparam logic [5:0] OpOr    = 6'b010001;
  localparam logic [5:0] OpAndi  = 6'b010010;
  localparam logic [5:0] OpOri   = 6'b010011;
  localparam logic [5:0] OpSll   = 6'b011000;
  localparam logic [5:0] OpSlti  = 6'b100111;
  localparam logic [5:0] OpSw    = 6'b110000;
  localparam logic [5:0] OpLw    = 6'b110001;
  localparam logic [5:0] OpBeq   = 6'b110100;
  localparam logic [5:0] OpBne   = 6'b110101;
  localparam logic [5:0] OpJ     = 6'b111000;
  localparam logic [5:0] OpJr    = 6'b111001;
  localparam logic [5:0] OpJal   = 6'b111010;

  typedef enum logic [2:0] {
    StIf    = 3'b000,
    StId    = 3'b001,
    StExeLs = 3'b010,
    StMem   = 3'b011,
    StWbLd  = 3'b100,
    StExeBr = 3'b101,
    StExeAl = 3'b110,
    StWbAl  = 3'b111
  } state_e;

  state_e           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;

  logic is_alu_r, is_alu_i, is_sll, is_mem, is_sw, is_br, is_beq, is_bne;
  logic is_j, is_jr, is_jal, is_halt, br_taken, halt_now;
  logic pc_wre, ir_wre, reg_wre, m_rd, m_wr;

  assign is_alu_r = (opCode == OpAdd) || (opCode == OpSub) || (opCode == OpAnd) ||
                    (opCode == OpOr)  || (opCode == OpSll);
  assign is_alu_i = (opCode == OpAddiu) || (opCode == OpAndi) || (opCode == OpOri) ||
                    (opCode == OpSlti);
  assign is_sll   = (opCode == OpSll);
  assign is_sw    = (opCode == OpSw);
  assign is_mem   = is_sw || (opCode == OpLw);
  assign is_beq   = (opCode == OpBeq);
  assign is_bne   = (opCode == OpBne);
  assign is_br    = is_beq || is_bne;
  assign is_j     = (opCode == OpJ);
  assign is_jr    = (opCode == OpJr);
  assign is_jal   = (opCode == OpJal);
  assign is_halt  = (opCode == HALT_OP);
  assign br_taken = (is_beq && zero) || (is_bne && !zero);

  // Once halted the opcode is ignored: the machine stays parked in ID until reset.
  assign halt_now = (state_q == StId) && (halted_q || is_halt);

  // ALU function and extension mode depend only on the opcode, so they hold through EXE..WB.
  always_comb begin
    ALUOp = 3'b000;
    case (opCode)
      OpSub, OpBeq, OpBne: ALUOp = 3'b001;
      OpAnd, OpAndi:       ALUOp = 3'b100;
      OpOr, OpOri:         ALUOp = 3'b101;
      OpSll:               ALUOp = 3'b011;
      OpSlti:              ALUOp = 3'b110;
      default:             ALUOp = 3'b000;
    endcase
    ExtSel = (opCode == OpAddiu) || (opCode == OpSlti) || is_mem || is_br;
  end

  always_comb begin
    state_d   = state_q;
    pc_wre    = 1'b0;
    ir_wre    = 1'b0;
    reg_wre   = 1'b0;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    PCSrc     = 2'b00;
    InsMemRW  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    unique case (state_q)
      StIf: begin
        InsMemRW = 1'b1;
        ir_wre   = 1'b1;
        state_d  = StId;
      end
      StId: begin
        if (halt_now) begin
          state_d = StId;
        end else if (is_j) begin
          pc_wre  = 1'b1;
          PCSrc   = 2'b11;
          state_d = StIf;
        end else if (is_jr) begin
          pc_wre  = 1'b1;
          PCSrc   = 2'b10;
          state_d = StIf;
        end else if (is_jal) begin
          pc_wre  = 1'b1;
          PCSrc   = 2'b11;
          reg_wre = 1'b1;
          state_d = StIf;
        end else if (is_br) begin
          state_d = StExeBr;
        end else if (is_mem) begin
          state_d = StExeLs;
        end else if (is_alu_r || is_alu_i) begin
          state_d = StExeAl;
        end else begin
          // Undefined opcode retires as a NOP.
          pc_wre  = 1'b1;
          state_d = StIf;
        end
      end
      StExeAl: begin
        ALUSrcA = is_sll;
        ALUSrcB = is_alu_i;
        state_d = StWbAl;
      end
      StWbAl: begin
        ALUSrcA   = is_sll;
        ALUSrcB   = is_alu_i;
        reg_wre   = 1'b1;
        RegDst    = is_alu_r ? 2'b10 : 2'b01;
        WrRegDSrc = 1'b1;
        pc_wre    = 1'b1;
        state_d   = StIf;
      end
      StExeBr: begin
        pc_wre  = 1'b1;
        PCSrc   = br_taken ? 2'b01 : 2'b00;
        state_d = StIf;
      end
      StExeLs: begin
        ALUSrcB = 1'b1;
        state_d = StMem;
      end
      StMem: begin
        ALUSrcB = 1'b1;
        if (is_sw) begin
          m_wr    = 1'b1;
          pc_wre  = 1'b1;
          state_d = StIf;
        end else begin
          m_rd    = 1'b1;
          state_d = StWbLd;
        end
      end
      StWbLd: begin
        ALUSrcB   = 1'b1;
        m_rd      = 1'b1;
        DBDataSrc = 1'b1;
        reg_wre   = 1'b1;
        RegDst    = 2'b01;
        WrRegDSrc = 1'b1;
        pc_wre    = 1'b1;
        state_d   = StIf;
      end
      default: state_d = StIf;
    endcase
  end

  // Strobes are forced low during reset so an aborted instruction never writes.
  assign PCWre       = pc_wre  && !Reset;
  assign IRWre       = ir_wre  && !Reset;
  assign RegWre      = reg_wre && !Reset;
  assign mRD         = m_rd    && !Reset;
  assign mWR         = m_wr    && !Reset;
  assign state       = state_q;
  assign instr_count = count_q;
  assign halted      = halted_q || halt_now;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIf;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (halt_now) begin
        halted_q <= 1'b1;
      end
      if (pc_wre) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Self-checking bench for multi_cycle_control_unit: directed and random instruction streams
// compared cycle by cycle against a per-instruction-class behavioural model.
module tb_multi_cycle_control_unit;

  logic        clk = 1'b0;
  logic        Reset;
  logic [5:0]  opCode;
  logic        zero;
  logic        PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
  logic        WrRegDSrc, RegWre, DBDataSrc, mRD, mWR, halted;
  logic [1:0]  PCSrc, RegDst;
  logic [2:0]  ALUOp, state;
  logic [31:0] instr_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_count = 0;

  localparam int KJ = 0, KJr = 1, KJal = 2, KNop = 3, KBr = 4;
  localparam int KAluR = 5, KAluI = 6, KSw = 7, KLw = 8;

  multi_cycle_control_unit dut (
    .clk         (clk),
    .Reset       (Reset),
    .opCode      (opCode),
    .zero        (zero),
    .PCWre       (PCWre),
    .PCSrc       (PCSrc),
    .IRWre       (IRWre),
    .InsMemRW    (InsMemRW),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .ExtSel      (ExtSel),
    .RegDst      (RegDst),
    .WrRegDSrc   (WrRegDSrc),
    .RegWre      (RegWre),
    .DBDataSrc   (DBDataSrc),
    .mRD         (mRD),
    .mWR         (mWR),
    .state       (state),
    .instr_count (instr_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000: return KAluR;
      6'b000010, 6'b010010, 6'b010011, 6'b100111:            return KAluI;
      6'b110000: return KSw;
      6'b110001: return KLw;
      6'b110100, 6'b110101: return KBr;
      6'b111000: return KJ;
      6'b111001: return KJr;
      6'b111010: return KJal;
      default:   return KNop;
    endcase
  endfunction

  function automatic int latency(input int k);
    case (k)
      KBr:              return 3;
      KAluR, KAluI, KSw: return 4;
      KLw:              return 5;
      default:          return 2;
    endcase
  endfunction

  // State visited at each cycle of an instruction, using the published state codes.
  function automatic int exp_state(input int k, input int s);
    if (s == 0) return 0;
    if (s == 1) return 1;
    if (k == KBr) return 5;
    if (k == KAluR || k == KAluI) return (s == 2) ? 6 : 7;
    return s; // load/store: 2, 3, 4
  endfunction

  function automatic int exp_aluop(input logic [5:0] op);
    case (op)
      6'b000001, 6'b110100, 6'b110101: return 1;
      6'b010000, 6'b010010:            return 4;
      6'b010001, 6'b010011:            return 5;
      6'b011000:                       return 3;
      6'b100111:                       return 6;
      default:                         return 0;
    endcase
  endfunction

  function automatic bit exp_ext(input logic [5:0] op);
    return (op == 6'b000010) || (op == 6'b100111) || (kind_of(op) == KSw) ||
           (kind_of(op) == KLw) || (kind_of(op) == KBr);
  endfunction

  // Runs one instruction from IF to retirement; zsel < 0 picks zero at random each cycle.
  task automatic run_instr(input logic [5:0] op, input int zsel);
    int  k;
    int  n;
    bit  last, rw, take;
    int  pcs;
    k = kind_of(op);
    n = latency(k);
    for (int s = 0; s < n; s++) begin
      if (s == 0) opCode = op;
      zero = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      #1;
      last = (s == n - 1);
      rw   = (k == KJal && s == 1) || ((k == KAluR || k == KAluI) && s == 3) ||
             (k == KLw && s == 4);
      check("state", 32'(state), 32'(exp_state(k, s)));
      check("PCWre", 32'(PCWre), 32'(last));
      check("IRWre", 32'(IRWre), 32'(s == 0));
      check("InsMemRW", 32'(InsMemRW), 32'(s == 0));
      check("RegWre", 32'(RegWre), 32'(rw));
      check("mWR", 32'(mWR), 32'(k == KSw && s == 3));
      check("mRD", 32'(mRD), 32'(k == KLw && s >= 3));
      check("halted", 32'(halted), 32'(0));
      if (last) begin
        take = (op == 6'b110100 && zero) || (op == 6'b110101 && !zero);
        pcs  = (k == KJ || k == KJal) ? 3 : (k == KJr) ? 2 : (k == KBr && take) ? 1 : 0;
        check("PCSrc", 32'(PCSrc), 32'(pcs));
      end
      if (rw) begin
        check("RegDst", 32'(RegDst), 32'((k == KJal) ? 0 : (k == KAluR) ? 2 : 1));
        check("WrRegDSrc", 32'(WrRegDSrc), 32'(k != KJal));
      end
      if (k == KLw && s == 4) check("DBDataSrc_ld", 32'(DBDataSrc), 32'(1));
      if ((k == KAluR || k == KAluI) && s == 3) check("DBDataSrc_al", 32'(DBDataSrc), 32'(0));
      if (s == 2 && (k == KAluR || k == KAluI)) begin
        check("ALUSrcA", 32'(ALUSrcA), 32'(op == 6'b011000));
        check("ALUSrcB_al", 32'(ALUSrcB), 32'(k == KAluI));
      end
      if (s == 2 && k == KBr) check("ALUSrcB_br", 32'(ALUSrcB), 32'(0));
      if (s == 2 && (k == KSw || k == KLw)) check("ALUSrcB_ls", 32'(ALUSrcB), 32'(1));
      if ((s >= 2 && (k == KAluR || k == KAluI)) || (s == 2 && (k == KBr || k == KSw || k == KLw)))
        check("ALUOp", 32'(ALUOp), 32'(exp_aluop(op)));
      if (s == 2 && (k == KAluI || k == KBr || k == KSw || k == KLw))
        check("ExtSel", 32'(ExtSel), 32'(exp_ext(op)));
      @(negedge clk);
    end
    exp_count++;
    #1;
    check("instr_count", instr_count, exp_count);
  endtask

  logic [5:0] ops [17] = '{6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000,
                           6'b000010, 6'b010010, 6'b010011, 6'b100111, 6'b110000,
                           6'b110001, 6'b110100, 6'b110101, 6'b111000, 6'b111001,
                           6'b111010, 6'b000011};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0]  op;
    logic [31:0] held_count;
    Reset  = 1'b1;
    opCode = 6'b000000;
    zero   = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'(0));
    check("rst_IRWre", 32'(IRWre), 32'(0));
    check("rst_PCWre", 32'(PCWre), 32'(0));
    check("rst_count", instr_count, 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    Reset = 1'b0;

    run_instr(6'b000010, -1); // addiu
    run_instr(6'b110100, 1);  // beq taken
    run_instr(6'b110100, 0);  // beq not taken
    run_instr(6'b110101, 1);  // bne not taken
    run_instr(6'b110101, 0);  // bne taken
    run_instr(6'b110001, -1); // lw
    run_instr(6'b110000, -1); // sw
    run_instr(6'b111010, -1); // jal
    run_instr(6'b111000, -1); // j
    run_instr(6'b111001, -1); // jr
    run_instr(6'b011000, -1); // sll
    run_instr(6'b000011, -1); // undefined -> NOP

    // Abort an ALU instruction in EXE_AL.
    opCode = 6'b000000;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid_state", 32'(state), 32'(6));
    Reset = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'(0));
    check("abort_RegWre", 32'(RegWre), 32'(0));
    check("abort_count", instr_count, 32'(0));
    @(negedge clk);
    #1;
    check("abort_RegWre2", 32'(RegWre), 32'(0));
    Reset     = 1'b0;
    exp_count = 0;

    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 16)];
      if (op == 6'b000011) begin
        do op = 6'($urandom); while (kind_of(op) != KNop || op == 6'b111111);
      end
      run_instr(op, -1);
    end

    held_count = exp_count;
    opCode = 6'b111111;
    #1;
    check("halt_if", 32'(state), 32'(0));
    @(negedge clk);
    #1;
    check("halt_state", 32'(state), 32'(1));
    check("halt_flag", 32'(halted), 32'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opCode = 6'($urandom);
      zero   = 1'($urandom_range(0, 1));
      #1;
      check("halt_hold_state", 32'(state), 32'(1));
      check("halt_hold_flag", 32'(halted), 32'(1));
      check("halt_PCWre", 32'(PCWre), 32'(0));
      check("halt_RegWre", 32'(RegWre), 32'(0));
      check("halt_mWR", 32'(mWR), 32'(0));
    end
    check("halt_count", instr_count, held_count);
    Reset = 1'b1;
    #1;
    check("unhalt_flag", 32'(halted), 32'(0));
    check("unhalt_state", 32'(state), 32'(0));
    @(negedge clk);
    Reset     = 1'b0;
    exp_count = 0;
    run_instr(6'b000001, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
